instruction_fetch_stage: RTL

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

---
 rtl/instruction_fetch_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, read-only instruction ROM, redirect mux,
// BOOT/RUN/HALT control and a delivered-instruction counter.
// Ports:
//   Clk, Reset (sync, active-high)
//   Stall, BranchTaken/BranchTarget, Jump/JumpTarget          -> PC control
//   InstructionOut, PCPlus4Out                                -> IF/ID register
//   PCCurrent, Valid, Halted, FetchCount                      -> status
// ROM contents are fixed at elaboration through MEM_INIT.
module instruction_fetch_stage #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter logic [31:0] MEM_INIT [MEM_DEPTH] = '{default: 32'h0}
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] InstructionOut,
  output logic [31:0] PCPlus4Out,
  output logic [31:0] PCCurrent,
  output logic        Valid,
  output logic        Halted,
  output logic [31:0] FetchCount
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        redirect;
  logic        valid;
  logic [31:0] instr;
  logic [AW-1:0] idx;

  // Redirect targets are word aligned, so their low bits never matter.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^{JumpTarget[1:0], BranchTarget[1:0]};

  function automatic logic in_range(input logic [31:0] pc);
    return ({2'b00, pc[31:2]} < MEM_DEPTH);
  endfunction

  assign idx      = pc_q[AW+1:2];
  assign redirect = Jump | BranchTaken;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    valid   = 1'b0;
    instr   = 32'h0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        // A redirect squashes the instruction fetched this cycle.
        if (!redirect && in_range(pc_q)) begin
          valid = 1'b1;
          instr = MEM_INIT[idx];
        end
        if (Jump)
          pc_d = {JumpTarget[31:2], 2'b00};
        else if (BranchTaken)
          pc_d = {BranchTarget[31:2], 2'b00};
        else if (Stall)
          pc_d = pc_q;
        else
          pc_d = pc_q + 32'd4;
        if (valid && !Stall)
          cnt_d = cnt_q + 32'd1;
        // Look ahead so HALT is already shown when PC leaves the ROM.
        if (!in_range(pc_d))
          state_d = HALT;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= 32'h0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign InstructionOut = instr;
  assign Valid          = valid;
  assign PCCurrent      = pc_q;
  assign PCPlus4Out     = pc_q + 32'd4;
  assign Halted         = (state_q == HALT);
  assign FetchCount     = cnt_q;

endmodule
